mig_port_arbiter: RTL and testbench
===================================

MIG_PORT_ARBITER -- requirements
Module: mig_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of client ports (2..8).
REQ-002 SHALL have parameter APP_ADDR_WIDTH, default 28, MIG application address width.
REQ-003 SHALL have parameter APP_CMD_WIDTH, default 3, MIG command width.
REQ-004 SHALL have parameter APP_DATA_WIDTH, default 128, MIG data width.
REQ-005 SHALL have parameter APP_MASK_WIDTH, default 16, MIG write byte-mask width.
REQ-006 SHALL have parameter TAG_DEPTH, default 16, outstanding-read capacity (power of two).
REQ-007 SHALL have one clock and an asynchronous, active-high reset; ports: clk  in  1  MIG ui_clk; i_rst  in  1  async active-high reset.
REQ-008 SHALL have client ports: i_req in NUM_PORTS; i_we in NUM_PORTS (1=write); i_addr in NUM_PORTS*APP_ADDR_WIDTH; i_data in NUM_PORTS*APP_DATA_WIDTH; i_mask in NUM_PORTS*APP_MASK_WIDTH; o_ack out NUM_PORTS (request accepted); o_data out APP_DATA_WIDTH (shared read data); o_data_valid out NUM_PORTS (one-hot read return); o_tag_err out 1 (sticky).
REQ-009 SHALL have MIG-side ports: app_addr out APP_ADDR_WIDTH; app_cmd out APP_CMD_WIDTH; app_en out 1; app_wdf_data out APP_DATA_WIDTH; app_wdf_mask out APP_MASK_WIDTH; app_wdf_wren out 1; app_wdf_end out 1; app_rdy in 1; app_wdf_rdy in 1; app_rd_data in APP_DATA_WIDTH; app_rd_data_valid in 1; i_init_calib_complete in 1.

Function
REQ-010 SHALL implement states WAIT_CALIB, IDLE, ISSUE; WAIT_CALIB->IDLE when i_init_calib_complete=1; no request is accepted in WAIT_CALIB.
REQ-011 In IDLE, SHALL select among asserted i_req by round-robin starting at the port after the last granted one, latch that port's we/addr/data/mask into registers, and move to ISSUE next cycle.
REQ-012 A read request SHALL be eligible only when the tag FIFO is not full; a full tag FIFO skips read requesters, write requesters remain eligible.
REQ-013 In ISSUE, app_en=1 with app_cmd=3'b000 (write) or 3'b001 (read) and app_addr from the latch; a read completes on app_rdy=1.
REQ-014 A write SHALL drive app_wdf_wren=app_wdf_end=1 with latched data/mask and complete only in a cycle where app_rdy=1 and app_wdf_rdy=1 together; neither strobe is asserted alone.
REQ-015 On completion, o_ack of the served port SHALL pulse for exactly one cycle, the round-robin pointer SHALL advance past it, a read SHALL push its port index to the tag FIFO, and the FSM SHALL return to IDLE (minimum 2 cycles per command).
REQ-016 Each app_rd_data_valid=1 SHALL pop one tag and, combinationally in that cycle, assert o_data_valid[tag] with o_data=app_rd_data; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-017 app_rd_data_valid=1 with an empty tag FIFO SHALL set o_tag_err=1 until reset and assert no o_data_valid bit.
REQ-018 Clients SHALL hold i_req and payload stable until o_ack; dropping i_req before o_ack is a protocol violation with undefined result.
REQ-019 i_init_calib_complete deasserting mid-ISSUE SHALL not abort the command in flight; the FSM returns to WAIT_CALIB after completion.

Reset
REQ-020 On i_rst=1 (asynchronous): FSM=WAIT_CALIB, round-robin pointer=port 0, tag FIFO empty, o_ack=0, app_en=0, app_wdf_wren=0, app_wdf_end=0, o_tag_err=0, latches and app_addr/app_cmd/app_wdf_data/app_wdf_mask=0.
REQ-021 Reset mid-ISSUE SHALL discard the command and all outstanding tags; read data arriving afterwards SHALL raise o_tag_err.

Structure
REQ-022 MIG command encodings (CMD_WRITE, CMD_READ) and the FSM state encoding SHALL live in a shared package with the MIG interface widths.
REQ-023 The tag FIFO SHALL be a sub-module tag_fifo (width clog2(NUM_PORTS), depth TAG_DEPTH, full/empty flags).

Verification
REQ-024 Calibration gate: i_req=4'b0001 with calib=0 for 10 cycles -> no app_en; calib=1 -> app_en within 2 cycles, o_ack[0] one pulse.
REQ-025 Round-robin: i_req=4'b1111 held, app_rdy=app_wdf_rdy=1 -> ack order 0,1,2,3,0, each 2 cycles apart.
REQ-026 Write stall: port 2 write addr 0x100, app_rdy=1, app_wdf_rdy=0 for 5 cycles -> app_en/app_wdf_wren held, no o_ack until wdf_rdy=1, then app_wdf_end=1 and o_ack[2] pulse.
REQ-027 Read return: reads from ports 3,1,0 in order, then 3 app_rd_data_valid beats 0xA,0xB,0xC -> o_data_valid 4'b1000,4'b0010,4'b0001 with matching data.
REQ-028 Tag full: TAG_DEPTH=4, 4 reads outstanding, port 1 read + port 2 write pending -> port 2 write issued, port 1 stalled until one valid beat returns.
REQ-029 Spurious data: app_rd_data_valid=1 with no outstanding reads -> o_tag_err=1 held, o_data_valid=0; cleared only by i_rst.

Source files
------------

// File: rtl/mig_port_arbiter_pkg.sv
// Shared MIG interface constants, command encodings and arbiter state type.
package mig_port_arbiter_pkg;

    localparam int MIG_ADDR_WIDTH = 28;
    localparam int MIG_CMD_WIDTH  = 3;
    localparam int MIG_DATA_WIDTH = 128;
    localparam int MIG_MASK_WIDTH = 16;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // state       | meaning
    // WAIT_CALIB  | memory not calibrated, no request accepted
    // IDLE        | round-robin pick among eligible requesters
    // ISSUE       | latched command driven on the app interface until accepted
    typedef enum logic [1:0] {
        ST_WAIT_CALIB = 2'd0,
        ST_IDLE       = 2'd1,
        ST_ISSUE      = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mig_port_arbiter_tag_fifo.sv
// Read-tag FIFO: records which port owns each outstanding read, in issue order.
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot a push needs.
    assign do_push  = push & (~full | do_pop);

    // Next pointer, storage and occupancy values.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO registers; reset empties the FIFO and discards all tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mig_port_arbiter.sv
// Round-robin arbiter sharing one MIG application port among several clients.
module mig_port_arbiter
    import mig_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int APP_ADDR_WIDTH = MIG_ADDR_WIDTH,
    parameter int APP_CMD_WIDTH  = MIG_CMD_WIDTH,
    parameter int APP_DATA_WIDTH = MIG_DATA_WIDTH,
    parameter int APP_MASK_WIDTH = MIG_MASK_WIDTH,
    parameter int TAG_DEPTH      = 16
) (
    input  logic                                clk,
    input  logic                                i_rst,
    input  logic [NUM_PORTS-1:0]                i_req,
    input  logic [NUM_PORTS-1:0]                i_we,
    input  logic [NUM_PORTS*APP_ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_PORTS*APP_DATA_WIDTH-1:0] i_data,
    input  logic [NUM_PORTS*APP_MASK_WIDTH-1:0] i_mask,
    output logic [NUM_PORTS-1:0]                o_ack,
    output logic [APP_DATA_WIDTH-1:0]           o_data,
    output logic [NUM_PORTS-1:0]                o_data_valid,
    output logic                                o_tag_err,
    output logic [APP_ADDR_WIDTH-1:0]           app_addr,
    output logic [APP_CMD_WIDTH-1:0]            app_cmd,
    output logic                                app_en,
    output logic [APP_DATA_WIDTH-1:0]           app_wdf_data,
    output logic [APP_MASK_WIDTH-1:0]           app_wdf_mask,
    output logic                                app_wdf_wren,
    output logic                                app_wdf_end,
    input  logic                                app_rdy,
    input  logic                                app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0]           app_rd_data,
    input  logic                                app_rd_data_valid,
    input  logic                                i_init_calib_complete
);
    localparam int PIDX_W = $clog2(NUM_PORTS);
    localparam logic [APP_CMD_WIDTH-1:0] CMD_WR = APP_CMD_WIDTH'(CMD_WRITE);
    localparam logic [APP_CMD_WIDTH-1:0] CMD_RD = APP_CMD_WIDTH'(CMD_READ);

    arb_state_e                state_q, state_d;
    logic [PIDX_W-1:0]         rr_q, rr_d;
    logic [PIDX_W-1:0]         port_q, port_d;
    logic [APP_CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APP_DATA_WIDTH-1:0] data_q, data_d;
    logic [APP_MASK_WIDTH-1:0] mask_q, mask_d;
    logic                      tag_err_q, tag_err_d;

    logic [NUM_PORTS-1:0]      elig;
    logic                      grant_found;
    logic [PIDX_W-1:0]         grant_idx;
    logic                      is_write, cmd_done;
    logic                      tag_full, tag_empty;
    logic [PIDX_W-1:0]         tag_pop_data;

    assign is_write = (cmd_q == CMD_WR);
    // Writes need both the command and the write-data FIFO in the same cycle.
    assign cmd_done = (state_q == ST_ISSUE) && app_rdy && (!is_write || app_wdf_rdy);
    // A full tag FIFO only blocks reads; writes never produce a tag.
    assign elig     = i_req & (i_we | {NUM_PORTS{~tag_full}});

    // Round-robin search starting at the port after the last one served.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!grant_found && elig[PIDX_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PIDX_W'(idx);
            end
        end
    end

    // Next-state, command latch and sticky tag-error logic.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        port_d    = port_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        tag_err_d = tag_err_q | (app_rd_data_valid & tag_empty);
        case (state_q)
            ST_WAIT_CALIB: begin
                if (i_init_calib_complete) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!i_init_calib_complete) begin
                    state_d = ST_WAIT_CALIB;
                end else if (grant_found) begin
                    port_d  = grant_idx;
                    cmd_d   = i_we[grant_idx] ? CMD_WR : CMD_RD;
                    addr_d  = i_addr[int'(grant_idx)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
                    data_d  = i_data[int'(grant_idx)*APP_DATA_WIDTH +: APP_DATA_WIDTH];
                    mask_d  = i_mask[int'(grant_idx)*APP_MASK_WIDTH +: APP_MASK_WIDTH];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Calibration loss is only honoured once the command is accepted.
                if (cmd_done) begin
                    rr_d    = (port_q == PIDX_W'(NUM_PORTS-1)) ? '0 : port_q + 1'b1;
                    state_d = i_init_calib_complete ? ST_IDLE : ST_WAIT_CALIB;
                end
            end
            default: state_d = ST_WAIT_CALIB;
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_WAIT_CALIB;
            rr_q      <= '0;
            port_q    <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            port_q    <= port_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            tag_err_q <= tag_err_d;
        end
    end

    tag_fifo #(
        .WIDTH (PIDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (i_rst),
        .push      (cmd_done & ~is_write),
        .push_data (port_q),
        .pop       (app_rd_data_valid),
        .pop_data  (tag_pop_data),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign app_en       = (state_q == ST_ISSUE);
    assign app_cmd      = cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_data = data_q;
    assign app_wdf_mask = mask_q;
    assign app_wdf_wren = app_en & is_write;
    assign app_wdf_end  = app_en & is_write;

    assign o_ack        = cmd_done ? (NUM_PORTS'(1) << port_q) : '0;
    assign o_data       = app_rd_data;
    assign o_data_valid = (app_rd_data_valid && !tag_empty) ? (NUM_PORTS'(1) << tag_pop_data) : '0;
    assign o_tag_err    = tag_err_q;

endmodule

// File: tb/tb_mig_port_arbiter.sv
// Bench for mig_port_arbiter: per-cycle reference model plus directed scenarios.
module tb_mig_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int CW = 3;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req, i_we;
    logic [N*AW-1:0] i_addr;
    logic [N*DW-1:0] i_data;
    logic [N*MW-1:0] i_mask;
    logic [N-1:0]    o_ack, o_data_valid;
    logic [DW-1:0]   o_data;
    logic            o_tag_err;
    logic [AW-1:0]   app_addr;
    logic [CW-1:0]   app_cmd;
    logic            app_en, app_wdf_wren, app_wdf_end;
    logic [DW-1:0]   app_wdf_data;
    logic [MW-1:0]   app_wdf_mask;
    logic            app_rdy, app_wdf_rdy, app_rd_data_valid, i_init_calib_complete;
    logic [DW-1:0]   app_rd_data;

    always #5 clk = ~clk;

    mig_port_arbiter #(
        .NUM_PORTS(N), .APP_ADDR_WIDTH(AW), .APP_CMD_WIDTH(CW),
        .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_data(i_data), .i_mask(i_mask), .o_ack(o_ack), .o_data(o_data),
        .o_data_valid(o_data_valid), .o_tag_err(o_tag_err), .app_addr(app_addr),
        .app_cmd(app_cmd), .app_en(app_en), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .i_init_calib_complete(i_init_calib_complete)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = waiting for calibration, 1 = free to pick, 2 = command on the bus
    int            m_mode, m_ptr, m_port;
    bit            m_we, m_err, m_full, m_done, m_found;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;
    int            m_tags[$];
    int            m_p;

    always @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            m_mode = 0; m_ptr = 0; m_port = 0; m_we = 0; m_err = 0;
            m_addr = '0; m_data = '0; m_mask = '0;
            m_tags.delete();
        end else begin
            m_full = (m_tags.size() >= TD);
            m_done = (m_mode == 2) && app_rdy && (!m_we || app_wdf_rdy);
            if (app_rd_data_valid) begin
                if (m_tags.size() > 0) void'(m_tags.pop_front());
                else m_err = 1;
            end
            if (m_mode == 0) begin
                if (i_init_calib_complete) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!i_init_calib_complete) m_mode = 0;
                else begin
                    m_found = 0;
                    for (int k = 0; k < N; k++) begin
                        m_p = (m_ptr + k) % N;
                        if (!m_found && i_req[m_p] && (i_we[m_p] || !m_full)) begin
                            m_found = 1;
                            m_port  = m_p;
                            m_we    = i_we[m_p];
                            m_addr  = i_addr[m_p*AW +: AW];
                            m_data  = i_data[m_p*DW +: DW];
                            m_mask  = i_mask[m_p*MW +: MW];
                            m_mode  = 2;
                        end
                    end
                end
            end else if (m_done) begin
                if (!m_we) m_tags.push_back(m_port);
                m_ptr  = (m_port + 1) % N;
                m_mode = i_init_calib_complete ? 1 : 0;
            end
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    logic [N-1:0] ack_seen;
    logic [N-1:0] e_ack, e_dv;
    bit           e_done;
    int           cyc = 0;
    int           en_cnt = 0;
    int           ack_cyc[$];
    int           ack_port[$];

    always @(negedge clk) begin
        if (i_rst) begin
            ack_seen = '0;
        end else begin
            e_done = (m_mode == 2) && app_rdy && (!m_we || app_wdf_rdy);
            e_ack  = e_done ? (N'(1) << m_port) : '0;
            e_dv   = (app_rd_data_valid && m_tags.size() > 0) ? (N'(1) << m_tags[0]) : '0;
            chk("app_en", app_en, m_mode == 2);
            chk("app_wdf_wren", app_wdf_wren, (m_mode == 2) && m_we);
            chk("app_wdf_end", app_wdf_end, (m_mode == 2) && m_we);
            chk("o_ack", o_ack, e_ack);
            chk("o_data_valid", o_data_valid, e_dv);
            chk("o_tag_err", o_tag_err, m_err);
            if (m_mode == 2) begin
                chk("app_addr", app_addr, m_addr);
                chk("app_cmd", app_cmd, m_we ? 3'b000 : 3'b001);
                if (m_we) begin
                    chk("app_wdf_data", app_wdf_data, m_data);
                    chk("app_wdf_mask", app_wdf_mask, m_mask);
                end
            end
            if (e_dv != '0) chk("o_data", o_data, app_rd_data);
            ack_seen = o_ack;
            for (int p = 0; p < N; p++) begin
                if (o_ack[p]) begin
                    ack_cyc.push_back(cyc);
                    ack_port.push_back(p);
                end
            end
            if (app_en) en_cnt++;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit hold_req = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_req) i_req = i_req & ~ack_seen;
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] a);
        i_we[p] = we;
        i_addr[p*AW +: AW] = a;
        i_data[p*DW +: DW] = {32'hC0DE_0000 + 32'(p), 64'h0, 4'h0, a};
        i_mask[p*MW +: MW] = MW'(16'h0F0F >> p);
    endtask

    task automatic do_req(input int p, input bit we, input logic [AW-1:0] a);
        bit got;
        got = 0;
        set_port(p, we, a);
        i_req[p] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (!i_req[p]) begin
                got = 1;
                break;
            end
        end
        chk($sformatf("ack_port%0d_timeout", p), got, 1'b1);
    endtask

    task automatic reset_dut();
        i_rst = 1'b1;
        i_req = '0;
        app_rd_data_valid = 1'b0;
        #12;
        i_rst = 1'b0;
        tick();
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [N-1:0] exp_dv, input string name);
        app_rd_data_valid = 1'b1;
        app_rd_data = d;
        @(negedge clk);
        chk(name, o_data_valid, exp_dv);
        if (exp_dv != '0) chk({name, "_data"}, o_data, d);
        tick();
        app_rd_data_valid = 1'b0;
    endtask

    function automatic int acks_for(input int p, input int from);
        int c;
        c = 0;
        for (int k = from; k < ack_port.size(); k++) if (ack_port[k] == p) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s, fn, n;
        bit  found;
        i_rst = 1'b1;
        i_req = '0; i_we = '0; i_addr = '0; i_data = '0; i_mask = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
        app_rd_data = '0; i_init_calib_complete = 1'b0;

        // reset values while reset is held
        #12;
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_wren", app_wdf_wren, 1'b0);
        chk("rst_end", app_wdf_end, 1'b0);
        chk("rst_ack", o_ack, '0);
        chk("rst_dv", o_data_valid, '0);
        chk("rst_tag_err", o_tag_err, 1'b0);
        chk("rst_addr", app_addr, '0);
        chk("rst_cmd", app_cmd, '0);
        chk("rst_wdata", app_wdf_data, '0);
        chk("rst_wmask", app_wdf_mask, '0);
        #11;
        i_rst = 1'b0;
        tick();

        // calibration gate: nothing issues while calib is low
        set_port(0, 1'b1, 28'h10);
        i_req[0] = 1'b1;
        repeat (10) tick();
        chk("calib_gate_no_en", en_cnt, 0);
        s = ack_port.size();
        i_init_calib_complete = 1'b1;
        // calib seen at 1st edge (->IDLE), grant at 2nd edge -> app_en on 3rd low phase
        fn = 0; found = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (app_en && !found) begin found = 1; fn = k; end
            tick();
        end
        repeat (4) tick();
        chk("calib_en_latency", fn, 3);
        chk("calib_ack0_pulses", acks_for(0, s), 1);

        // round robin with every port requesting continuously
        reset_dut();
        for (int p = 0; p < N; p++) set_port(p, 1'b1, AW'(32'h200 + p));
        hold_req = 1;
        s = ack_port.size();
        i_req = 4'hF;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ack_port.size() >= s + 5) break;
        end
        i_req = '0;
        hold_req = 0;
        chk("rr_ack_count", ack_port.size() >= s + 5, 1'b1);
        if (ack_port.size() >= s + 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), ack_port[s+k], k % 4);
            for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), ack_cyc[s+k] - ack_cyc[s+k-1], 2);
        end
        tick();

        // write stall on wdf_rdy, with calibration dropping mid-command
        app_wdf_rdy = 1'b0;
        set_port(2, 1'b1, 28'h100);
        i_req[2] = 1'b1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (app_en) begin found = 1; break; end
            tick();
        end
        chk("stall_en_seen", found, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_en", app_en, 1'b1);
            chk("stall_wren", app_wdf_wren, 1'b1);
            chk("stall_no_ack", o_ack, '0);
            tick();
            if (k == 0) i_init_calib_complete = 1'b0;
        end
        app_wdf_rdy = 1'b1;
        @(negedge clk);
        chk("stall_ack2", o_ack, 4'b0100);
        chk("stall_wdf_end", app_wdf_end, 1'b1);
        chk("stall_addr", app_addr, 28'h100);
        tick();
        repeat (2) tick();
        i_init_calib_complete = 1'b1;
        repeat (2) tick();

        // read return order follows issue order
        do_req(3, 1'b0, 28'h300);
        do_req(1, 1'b0, 28'h310);
        do_req(0, 1'b0, 28'h320);
        tick();
        beat(128'hA, 4'b1000, "rd_ret0");
        beat(128'hB, 4'b0010, "rd_ret1");
        beat(128'hC, 4'b0001, "rd_ret2");
        tick();

        // tag FIFO full: reads wait, writes pass
        do_req(0, 1'b0, 28'h400);
        do_req(3, 1'b0, 28'h410);
        do_req(0, 1'b0, 28'h420);
        do_req(3, 1'b0, 28'h430);
        s = ack_port.size();
        set_port(1, 1'b0, 28'h440);
        set_port(2, 1'b1, 28'h450);
        i_req[1] = 1'b1;
        i_req[2] = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!i_req[2]) begin found = 1; break; end
        end
        chk("full_write_issued", found, 1'b1);
        repeat (5) tick();
        chk("full_read_stalled", acks_for(1, s), 0);
        beat(128'h1111, 4'b0001, "full_pop");
        found = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!i_req[1]) begin found = 1; break; end
        end
        chk("full_read_released", found, 1'b1);
        tick();
        beat(128'h21, 4'b1000, "drain0");
        beat(128'h22, 4'b0001, "drain1");
        beat(128'h23, 4'b1000, "drain2");
        beat(128'h24, 4'b0010, "drain3");

        // reset mid-command discards outstanding tags; later data is spurious
        do_req(1, 1'b0, 28'h500);
        app_rdy = 1'b0;
        set_port(2, 1'b0, 28'h510);
        i_req[2] = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("midissue_en", app_en, 1'b1);
        tick();
        reset_dut();
        app_rdy = 1'b1;
        repeat (2) tick();
        beat(128'hDEAD, 4'b0000, "spurious_dv");
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_tag_err) n++;
            tick();
        end
        chk("tag_err_sticky", n, 5);
        reset_dut();
        @(negedge clk);
        chk("tag_err_cleared", o_tag_err, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
